voice_allocator: RTL
====================

Name: voice_allocator

Overview:
- Converts a stream of note-on/note-off events into the per-voice `frequencies[7:0]` and `voice_volumes[7:0]` arrays that drive the 8-voice polyphonic synthesizer.
- Assigns each note to a voice: retrigger if the key is already sounding, else the lowest-index free voice, else steal the least-recently-allocated voice.
- Runs a per-voice linear attack/sustain/release envelope that sets each voice's volume.

Parameters:
- ENV_DIV, 1024, clk cycles per envelope tick (≥16).
- ATTACK_STEP, 64, level increment per tick in ATTACK.
- RELEASE_STEP, 16, level decrement per tick in RELEASE.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  block can accept an event.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_key  in  7  key number.
- ev_vel  in  7  velocity; used on note-on only.
- ev_freq  in  32  oscillator frequency in Hz; used on note-on only.
- frequencies  out  32x8  per-voice frequency.
- voice_volumes  out  32x8  per-voice volume, equal to {24'b0, level[15:8]}.
- voice_active  out  8  voice state is not IDLE.
- busy  out  1  event FSM is not in IDLE.

Behaviour:
- Reset values (asynchronous):
  - ev_ready=1, busy=0.
  - All frequencies=0, voice_volumes=0, voice_active=0.
  - All voice states IDLE, levels 0, keys 0.
  - LRU rank[i]=i.
  - Envelope divider=0.
- Reset asserted mid-event discards the event entirely; no partial voice update is allowed.
- Event FSM states: IDLE, SCAN, COMMIT.
  - IDLE: ev_ready=1. ev_valid&ev_ready latches ev_* into a holding register and moves to SCAN with scan index 0.
  - SCAN: one voice per cycle, index 0..7, 8 cycles, ev_ready=0. Records:
    - first voice with matching key and state ≠ IDLE (match),
    - lowest-index IDLE voice (free),
    - voice with rank==7 (oldest).
    - After index 7, go to COMMIT.
  - COMMIT: one cycle, apply the action below, return to IDLE.
- Latency: handshake in cycle 0; outputs reflect the event in cycle 10; next event acceptable in cycle 10.
- Note-on target selection, in priority order: match → free → oldest.
- Note-on action on the target voice:
  - key←ev_key, frequencies←ev_freq, target level←{ev_vel,9'b0}, state←ATTACK.
  - Current level is kept; no click to zero on retrigger or steal.
  - LRU update: every voice with rank < target's rank gets rank+1; target rank←0. Ranks stay a permutation of 0..7.
- Note-off action: match found → state←RELEASE. No match → no change (ranks unchanged).
- Envelope tick: divider counts 0..ENV_DIV-1; a tick is one pulse at wrap. On a tick every voice updates in parallel:
  - ATTACK: level←min(level+ATTACK_STEP, target). Reaching target → SUSTAIN. If level>target on entry (retrigger at lower velocity), level←target and go to SUSTAIN.
  - SUSTAIN: level held.
  - RELEASE: level←max(level−RELEASE_STEP, 0). Reaching 0 → IDLE.
  - IDLE: level=0.
  - All arithmetic is 17-bit with saturation; no wrap-around.
- Simultaneous tick and COMMIT on the same voice: COMMIT wins for that voice (its tick is skipped). Other voices tick normally.
- frequencies of a voice are held after it returns to IDLE (volume is 0, so it is silent).
- ev_* inputs are sampled only on the handshake cycle.

Test Plan:
- Reset, then note-on key=60 vel=127 freq=440 → cycle 10: frequencies[0]=440, voice_active=8'h01, ev_ready=1. After 1016 ticks (65024/64 rounded up): voice_volumes[0]=254, state SUSTAIN.
- Eight note-ons keys 60..67 → voices 0..7 active. Ninth note-on key 70 freq=880 → voice 0 (oldest) stolen: frequencies[0]=880, ranks: voice0=0, voice1=7.
- Note-on key 60 twice (vel 127, then vel 32 after sustain) → both use voice 0, voice_active=8'h01. Level drops to 16384 on the next tick: voice_volumes[0]=64.
- Note-off key 60 from sustain level 65024 → 4064 ticks later voice_active[0]=0, voice_volumes[0]=0. Note-off key 99 (unused) → no change, ev_ready returns after 10 cycles.
- ev_valid held high with back-to-back events → one accepted every 10 cycles. ev_ready=0 during SCAN/COMMIT, and the held inputs are not re-sampled.
- Assert reset during SCAN of a note-on → all outputs at reset values immediately. After release, no voice is active.

Source files
------------

// File: rtl/voice_allocator.sv
// 8-voice note allocator: retrigger / lowest free / steal oldest,
// plus a per-voice linear attack-sustain-release envelope.
module voice_allocator #(
  parameter int ENV_DIV      = 1024,
  parameter int ATTACK_STEP  = 64,
  parameter int RELEASE_STEP = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ev_valid,
  output logic             ev_ready,
  input  logic             ev_on,
  input  logic [6:0]       ev_key,
  input  logic [6:0]       ev_vel,
  input  logic [31:0]      ev_freq,
  output logic [7:0][31:0] frequencies,
  output logic [7:0][31:0] voice_volumes,
  output logic [7:0]       voice_active,
  output logic             busy
);

  localparam int DW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam logic [16:0] ASTEP = 17'(ATTACK_STEP);
  localparam logic [16:0] RSTEP = 17'(RELEASE_STEP);

  typedef enum logic [1:0] {E_IDLE, E_SCAN, E_COMMIT} ev_state_e;
  typedef enum logic [1:0] {V_IDLE, V_ATTACK, V_SUSTAIN, V_RELEASE} v_state_e;

  ev_state_e ev_state_q, ev_state_d;
  logic [2:0] idx_q, idx_d;
  logic       match_vld_q, match_vld_d;
  logic [2:0] match_q, match_d;
  logic       free_vld_q, free_vld_d;
  logic [2:0] free_q, free_d;
  logic [2:0] old_q, old_d;
  logic       accept, commit;

  logic        hold_on_q;
  logic [6:0]  hold_key_q, hold_vel_q;
  logic [31:0] hold_freq_q;

  logic [DW-1:0] div_q, div_d;
  logic          tick;

  v_state_e    vst_q [8];
  v_state_e    vst_d [8];
  logic [15:0] lvl_q [8];
  logic [15:0] lvl_d [8];
  logic [15:0] tgt_q [8];
  logic [15:0] tgt_d [8];
  logic [6:0]  key_q [8];
  logic [6:0]  key_d [8];
  logic [31:0] frq_q [8];
  logic [31:0] frq_d [8];
  logic [2:0]  rank_q [8];
  logic [2:0]  rank_d [8];

  logic [2:0] tgt_idx;
  logic       apply_on, apply_off;

  assign ev_ready = (ev_state_q == E_IDLE);
  assign busy     = ~ev_ready;

  assign tick  = (div_q == DW'(ENV_DIV - 1));
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_comb begin
    ev_state_d  = ev_state_q;
    idx_d       = idx_q;
    match_vld_d = match_vld_q;
    match_d     = match_q;
    free_vld_d  = free_vld_q;
    free_d      = free_q;
    old_d       = old_q;
    accept      = 1'b0;
    commit      = 1'b0;
    unique case (ev_state_q)
      E_IDLE: begin
        if (ev_valid) begin
          accept      = 1'b1;
          ev_state_d  = E_SCAN;
          idx_d       = 3'd0;
          match_vld_d = 1'b0;
          free_vld_d  = 1'b0;
          old_d       = 3'd0;
        end
      end
      E_SCAN: begin
        if (!match_vld_q && vst_q[idx_q] != V_IDLE
            && key_q[idx_q] == hold_key_q) begin
          match_vld_d = 1'b1;
          match_d     = idx_q;
        end
        if (!free_vld_q && vst_q[idx_q] == V_IDLE) begin
          free_vld_d = 1'b1;
          free_d     = idx_q;
        end
        if (rank_q[idx_q] == 3'd7) old_d = idx_q;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) ev_state_d = E_COMMIT;
      end
      E_COMMIT: begin
        commit     = 1'b1;
        ev_state_d = E_IDLE;
      end
      default: ev_state_d = E_IDLE;
    endcase
  end

  assign tgt_idx   = match_vld_q ? match_q
                   : free_vld_q ? free_q : old_q;
  assign apply_on  = commit & hold_on_q;
  assign apply_off = commit & ~hold_on_q & match_vld_q;

  // Commit is applied after the tick so it overrides that voice's tick.
  always_comb begin
    logic [16:0] up;
    for (int i = 0; i < 8; i++) begin
      vst_d[i]  = vst_q[i];
      lvl_d[i]  = lvl_q[i];
      tgt_d[i]  = tgt_q[i];
      key_d[i]  = key_q[i];
      frq_d[i]  = frq_q[i];
      rank_d[i] = rank_q[i];
      up = {1'b0, lvl_q[i]} + ASTEP;
      if (tick) begin
        unique case (vst_q[i])
          V_ATTACK: begin
            if (lvl_q[i] >= tgt_q[i] || up >= {1'b0, tgt_q[i]}) begin
              lvl_d[i] = tgt_q[i];
              vst_d[i] = V_SUSTAIN;
            end else begin
              lvl_d[i] = up[15:0];
            end
          end
          V_RELEASE: begin
            if ({1'b0, lvl_q[i]} <= RSTEP) begin
              lvl_d[i] = '0;
              vst_d[i] = V_IDLE;
            end else begin
              lvl_d[i] = lvl_q[i] - RSTEP[15:0];
            end
          end
          V_SUSTAIN: lvl_d[i] = lvl_q[i];
          default:   lvl_d[i] = '0;
        endcase
      end
      if (apply_on) begin
        if (rank_q[i] < rank_q[tgt_idx]) rank_d[i] = rank_q[i] + 3'd1;
        if (tgt_idx == 3'(i)) begin
          rank_d[i] = 3'd0;
          key_d[i]  = hold_key_q;
          frq_d[i]  = hold_freq_q;
          tgt_d[i]  = {hold_vel_q, 9'b0};
          vst_d[i]  = V_ATTACK;
          lvl_d[i]  = lvl_q[i];
        end
      end
      if (apply_off && match_q == 3'(i)) begin
        vst_d[i] = V_RELEASE;
        lvl_d[i] = lvl_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      frequencies[i]   = frq_q[i];
      voice_volumes[i] = {24'b0, lvl_q[i][15:8]};
      voice_active[i]  = (vst_q[i] != V_IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_state_q  <= E_IDLE;
      idx_q       <= '0;
      match_vld_q <= 1'b0;
      match_q     <= '0;
      free_vld_q  <= 1'b0;
      free_q      <= '0;
      old_q       <= '0;
      hold_on_q   <= 1'b0;
      hold_key_q  <= '0;
      hold_vel_q  <= '0;
      hold_freq_q <= '0;
      div_q       <= '0;
      for (int i = 0; i < 8; i++) begin
        vst_q[i]  <= V_IDLE;
        lvl_q[i]  <= '0;
        tgt_q[i]  <= '0;
        key_q[i]  <= '0;
        frq_q[i]  <= '0;
        rank_q[i] <= 3'(i);
      end
    end else begin
      ev_state_q  <= ev_state_d;
      idx_q       <= idx_d;
      match_vld_q <= match_vld_d;
      match_q     <= match_d;
      free_vld_q  <= free_vld_d;
      free_q      <= free_d;
      old_q       <= old_d;
      div_q       <= div_d;
      if (accept) begin
        hold_on_q   <= ev_on;
        hold_key_q  <= ev_key;
        hold_vel_q  <= ev_vel;
        hold_freq_q <= ev_freq;
      end
      for (int i = 0; i < 8; i++) begin
        vst_q[i]  <= vst_d[i];
        lvl_q[i]  <= lvl_d[i];
        tgt_q[i]  <= tgt_d[i];
        key_q[i]  <= key_d[i];
        frq_q[i]  <= frq_d[i];
        rank_q[i] <= rank_d[i];
      end
    end
  end

endmodule
